tx_sched: RTL and testbench
===========================

Name: tx_sched

Overview:
- Round-robin scheduler that sits in front of the 4-input priority TX mux and shares it among up to four 16-bit word producers (CCD pixel, housekeeping, status, command echo).
- Each producer gets a one-entry holding register.
- The scheduler asserts exactly one mux request at a time and holds that request and its data stable for the whole header/MSB/LSB transfer.
- It counts FIFO write pulses to detect transfer completion, then runs the release handshake.

Parameters:
TIMEOUT, 1024, cycles allowed between asserting mux_req and seeing mux_accept before abort (>=2)
CNT_W, 16, width of transmitted-word counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  reset, asynchronous, active-low
enable  in  1  1 = may start new transfers; 0 = finish current, start none
src_valid  in  4  producer k offers src_data_k
src_data_0..src_data_3  in  16 each  producer words
src_ready  out  4  producer k holding register empty (combinational = ~pending[k])
mux_req  out  4  one-hot-or-zero request to TX mux
mux_in_0..mux_in_3  out  16 each  holding register k, driven continuously
mux_accept  in  4  accept lines from TX mux
mux_winc  in  1  TX FIFO write strobe from mux (observed, not driven)
busy  out  1  FSM not in IDLE
err_timeout  out  1  sticky; set on accept timeout, cleared only by reset
tx_count  out  CNT_W  completed transfers, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, rst_n=0): pending=0, hold regs=0, mux_req=0, busy=0, err_timeout=0, tx_count=0, last=3, FSM=IDLE. src_ready reads 4'hF after reset.
- Capture: src_valid[k] & src_ready[k] at a clock edge -> hold_k<=src_data_k, pending[k]<=1.
  - Capture is independent per source and is allowed in any FSM state.
  - hold_k never changes while pending[k]=1.
- Arbitration: in IDLE with enable=1 and pending!=0, cur <= first pending source searching last+1, last+2, ... modulo 4.
  - Next state REQ; mux_req registered, equals 1<<cur from the next cycle.
- FSM states:
  - IDLE: mux_req=0. Arbitrate as above.
  - REQ: mux_req=1<<cur, timer counts.
    - mux_accept[cur]=1 -> SEND, timer cleared, wcnt=0.
    - Timer reaches TIMEOUT-1 -> err_timeout<=1, mux_req<=0, -> DRAIN. pending[cur] is kept, so the source is retried after later sources per round-robin; last<=cur.
  - SEND: mux_req held. Each mux_winc=1 cycle increments wcnt.
    - On the cycle the third pulse is seen, mux_req<=0, -> RELEASE.
    - mux_winc pulses outside SEND are ignored.
  - RELEASE: mux_req=0.
    - mux_accept[cur]=0 -> pending[cur]<=0, last<=cur, tx_count<=tx_count+1, -> IDLE.
    - No timeout in this state.
  - DRAIN: mux_req=0; wait mux_accept==0 -> IDLE.
- Ordering and latency:
  - Never assert mux_req while any mux_accept bit is high in IDLE; wait for all to be low.
  - This guarantees the mux has returned to idle before a new request.
  - Minimum gap between consecutive transfers: 1 IDLE cycle.
- enable: sampled only in IDLE. Deassertion mid-transfer has no effect until return to IDLE.
- Source k becomes ready again the cycle after its pending clears. Capture and clear never coincide for the same k.
- busy=1 in every state except IDLE.
- Reset mid-transfer: all state cleared immediately; mux_req drops asynchronously with rst_n.

Test Plan:
- Single word: src 2 offers 16'hA5C3 with mux model idle. Required:
  - mux_req=4'b0100 two cycles later.
  - Model writes 8'h02, 8'hA5, 8'hC3.
  - After the third winc, mux_req=0.
  - After accept falls, tx_count=1 and src_ready=4'hF.
- Round-robin: all four sources valid the same cycle (16'h1000..16'h1003), continuously refilled.
  - Grant order is 0,1,2,3,0,...
  - Source 0 is never granted twice in a row while others are pending.
- FIFO backpressure: wfull held in the model for 20 cycles during the MSB phase.
  - mux_req and mux_in_cur stay stable throughout.
  - Exactly 3 winc are counted; the transfer completes correctly.
- Timeout: TIMEOUT=8, model never raises accept.
  - mux_req drops after 8 cycles, err_timeout=1 and stays 1.
  - pending retained; the word is sent once the model is re-enabled.
- enable=0 asserted during SEND of source 1: the transfer completes.
  - Pending source 3 is not requested until enable=1.
- Reset mid-SEND: rst_n=0 while the mux is in SEND.
  - mux_req=0, src_ready=4'hF, tx_count=0, err_timeout=0 with no clock edge needed.

Source files
------------

// File: rtl/tx_sched.sv
// Round-robin scheduler that shares the 4-input TX mux among four 16-bit word producers.
// Holds one request and its data stable until three FIFO writes complete, then runs the release handshake.
module tx_sched #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [3:0]       src_valid,
  input  logic [15:0]      src_data_0,
  input  logic [15:0]      src_data_1,
  input  logic [15:0]      src_data_2,
  input  logic [15:0]      src_data_3,
  output logic [3:0]       src_ready,
  output logic [3:0]       mux_req,
  output logic [15:0]      mux_in_0,
  output logic [15:0]      mux_in_1,
  output logic [15:0]      mux_in_2,
  output logic [15:0]      mux_in_3,
  input  logic [3:0]       mux_accept,
  input  logic             mux_winc,
  output logic             busy,
  output logic             err_timeout,
  output logic [CNT_W-1:0] tx_count
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_SEND,
    S_RELEASE,
    S_DRAIN
  } state_t;

  state_t           state, state_nxt;
  logic [3:0]       pending;
  logic [3:0]       cap;
  logic [3:0]       clr;
  logic [15:0]      src_data [4];
  logic [15:0]      hold     [4];
  logic [1:0]       last;
  logic [1:0]       cur;
  logic [1:0]       pick;
  logic             pick_vld;
  logic [TMR_W-1:0] timer;
  logic [1:0]       wcnt;
  logic             grant, accepted, timed_out, send_done, released;

  assign src_data[0] = src_data_0;
  assign src_data[1] = src_data_1;
  assign src_data[2] = src_data_2;
  assign src_data[3] = src_data_3;

  assign mux_in_0 = hold[0];
  assign mux_in_1 = hold[1];
  assign mux_in_2 = hold[2];
  assign mux_in_3 = hold[3];

  assign src_ready = ~pending;
  assign busy      = (state != S_IDLE);
  // A source being cleared is still pending, so it cannot be captured on the same edge.
  assign cap       = src_valid & ~pending;
  assign clr       = released ? (4'b0001 << cur) : '0;

  // Search starts just after the last served source and wraps around.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int unsigned i = 1; i <= 4; i++) begin
      if (!pick_vld && pending[last + 2'(i)]) begin
        pick     = last + 2'(i);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    accepted  = 1'b0;
    timed_out = 1'b0;
    send_done = 1'b0;
    released  = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable && pick_vld && (mux_accept == '0)) begin
          grant     = 1'b1;
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (mux_accept[cur]) begin
          accepted  = 1'b1;
          state_nxt = S_SEND;
        end else if (timer == TMR_W'(TIMEOUT - 1)) begin
          timed_out = 1'b1;
          state_nxt = S_DRAIN;
        end
      end
      S_SEND: begin
        if (mux_winc && (wcnt == 2'd2)) begin
          send_done = 1'b1;
          state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!mux_accept[cur]) begin
          released  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (mux_accept == '0) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= '0;
      for (int unsigned k = 0; k < 4; k++) hold[k] <= '0;
      mux_req     <= '0;
      err_timeout <= 1'b0;
      tx_count    <= '0;
      last        <= 2'd3;
      cur         <= '0;
      timer       <= '0;
      wcnt        <= '0;
    end else begin
      pending <= (pending | cap) & ~clr;
      for (int unsigned k = 0; k < 4; k++) begin
        if (cap[k]) hold[k] <= src_data[k];
      end

      if (grant) begin
        cur     <= pick;
        mux_req <= 4'b0001 << pick;
        timer   <= '0;
      end else if (accepted) begin
        timer <= '0;
        wcnt  <= '0;
      end else if (timed_out) begin
        err_timeout <= 1'b1;
        mux_req     <= '0;
        last        <= cur;
      end else if (state == S_REQ) begin
        timer <= timer + 1'b1;
      end

      if (state == S_SEND && mux_winc) begin
        if (send_done) mux_req <= '0;
        else           wcnt    <= wcnt + 2'd1;
      end

      if (released) begin
        last     <= cur;
        tx_count <= tx_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tx_sched.sv
// Directed bench for tx_sched: a small TX mux model serves requests and the results are compared
// against hand-computed grant order, transmitted bytes, counters and flags.
module tb_tx_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable;
  logic [3:0]  src_valid;
  logic [15:0] src_data_0, src_data_1, src_data_2, src_data_3;
  logic [3:0]  src_ready;
  logic [3:0]  mux_req;
  logic [15:0] mux_in_0, mux_in_1, mux_in_2, mux_in_3;
  logic [3:0]  mux_accept;
  logic        mux_winc;
  logic        busy;
  logic        err_timeout;
  logic [15:0] tx_count;

  int n_cmp = 0;
  int n_err = 0;

  int          k, n;
  logic [7:0]  b0, b1, b2;

  tx_sched #(.TIMEOUT(8), .CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .src_valid   (src_valid),
    .src_data_0  (src_data_0),
    .src_data_1  (src_data_1),
    .src_data_2  (src_data_2),
    .src_data_3  (src_data_3),
    .src_ready   (src_ready),
    .mux_req     (mux_req),
    .mux_in_0    (mux_in_0),
    .mux_in_1    (mux_in_1),
    .mux_in_2    (mux_in_2),
    .mux_in_3    (mux_in_3),
    .mux_accept  (mux_accept),
    .mux_winc    (mux_winc),
    .busy        (busy),
    .err_timeout (err_timeout),
    .tx_count    (tx_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mux_word(input int idx);
    case (idx)
      0:       return mux_in_0;
      1:       return mux_in_1;
      2:       return mux_in_2;
      default: return mux_in_3;
    endcase
  endfunction

  task automatic do_reset();
    rst_n      = 1'b0;
    enable     = 1'b1;
    src_valid  = '0;
    src_data_0 = '0;
    src_data_1 = '0;
    src_data_2 = '0;
    src_data_3 = '0;
    mux_accept = '0;
    mux_winc   = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
  endtask

  // TX mux model: accept the request, write header/MSB/LSB (optionally stalling before MSB), release.
  task automatic serve(input int stall, input bit drop_en,
                       output int gk, output logic [7:0] h, output logic [7:0] m, output logic [7:0] l);
    int          w8;
    bit          ok;
    logic [3:0]  req0;
    logic [15:0] w;
    gk = -1; h = '0; m = '0; l = '0;
    w8 = 0;
    while (mux_req == 4'b0 && w8 < 50) begin
      tick();
      w8++;
    end
    check("req_seen", {31'b0, mux_req != 4'b0}, 32'd1);
    if (mux_req == 4'b0) return;
    check("req_onehot", {31'b0, $onehot(mux_req)}, 32'd1);
    gk   = mux_req[0] ? 0 : mux_req[1] ? 1 : mux_req[2] ? 2 : 3;
    req0 = mux_req;
    w    = mux_word(gk);
    mux_accept = req0;
    tick();
    if (drop_en) enable = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        for (int s = 0; s < stall; s++) begin
          if (mux_req !== req0 || mux_word(gk) !== w) ok = 1'b0;
          tick();
        end
      end
      if (mux_req !== req0 || mux_word(gk) !== w) ok = 1'b0;
      case (i)
        0:       h = 8'(gk);
        1:       m = mux_word(gk)[15:8];
        default: l = mux_word(gk)[7:0];
      endcase
      mux_winc = 1'b1;
      tick();
      mux_winc = 1'b0;
    end
    check("req_stable", {31'b0, ok}, 32'd1);
    check("req_drop", {28'b0, mux_req}, 32'd0);
    mux_accept = '0;
    tick();
    check("release_idle", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    do_reset();

    // Reset state
    check("rst_req",   {28'b0, mux_req},   32'd0);
    check("rst_ready", {28'b0, src_ready}, 32'hF);
    check("rst_busy",  {31'b0, busy},      32'd0);
    check("rst_err",   {31'b0, err_timeout}, 32'd0);
    check("rst_cnt",   {16'b0, tx_count},  32'd0);
    check("rst_hold",  {16'b0, mux_in_2},  32'd0);

    // Single word from source 2
    src_valid  = 4'b0100;
    src_data_2 = 16'hA5C3;
    tick();
    src_valid = '0;
    check("sw_ready", {28'b0, src_ready}, 32'hB);
    check("sw_req0",  {28'b0, mux_req},   32'd0);
    check("sw_hold",  {16'b0, mux_in_2},  32'hA5C3);
    tick();
    check("sw_req",   {28'b0, mux_req},   32'h4);
    check("sw_busy",  {31'b0, busy},      32'd1);
    serve(0, 1'b0, k, b0, b1, b2);
    check("sw_k",     k,                  32'd2);
    check("sw_hdr",   {24'b0, b0},        32'h02);
    check("sw_msb",   {24'b0, b1},        32'hA5);
    check("sw_lsb",   {24'b0, b2},        32'hC3);
    check("sw_cnt",   {16'b0, tx_count},  32'd1);
    check("sw_rdy2",  {28'b0, src_ready}, 32'hF);

    // Round-robin with all sources continuously valid
    do_reset();
    src_data_0 = 16'h1000;
    src_data_1 = 16'h1001;
    src_data_2 = 16'h1002;
    src_data_3 = 16'h1003;
    src_valid  = 4'hF;
    for (int i = 0; i < 6; i++) begin
      serve(0, 1'b0, k, b0, b1, b2);
      check("rr_grant", k, i % 4);
      check("rr_word", {16'b0, b1, b2}, 32'h1000 + (i % 4));
    end
    src_valid = '0;
    check("rr_cnt", {16'b0, tx_count}, 32'd6);

    // FIFO backpressure: 20-cycle stall before the MSB write
    do_reset();
    src_valid  = 4'b0010;
    src_data_1 = 16'hBEEF;
    tick();
    src_valid = '0;
    serve(20, 1'b0, k, b0, b1, b2);
    check("bp_k",   k,                 32'd1);
    check("bp_hdr", {24'b0, b0},       32'h01);
    check("bp_word", {16'b0, b1, b2},  32'hBEEF);
    check("bp_cnt", {16'b0, tx_count}, 32'd1);

    // enable dropped during SEND of source 1; source 3 must wait
    do_reset();
    src_valid  = 4'b1010;
    src_data_1 = 16'h1111;
    src_data_3 = 16'h3333;
    tick();
    src_valid = '0;
    serve(0, 1'b1, k, b0, b1, b2);
    check("en_k",    k,                  32'd1);
    check("en_word", {16'b0, b1, b2},    32'h1111);
    check("en_cnt",  {16'b0, tx_count},  32'd1);
    check("en_pend", {28'b0, src_ready}, 32'h7);
    repeat (5) tick();
    check("en_hold_req",  {28'b0, mux_req}, 32'd0);
    check("en_hold_busy", {31'b0, busy},    32'd0);
    enable = 1'b1;
    serve(0, 1'b0, k, b0, b1, b2);
    check("en_k3",    k,                 32'd3);
    check("en_word3", {16'b0, b1, b2},   32'h3333);
    check("en_cnt2",  {16'b0, tx_count}, 32'd2);

    // Accept timeout with TIMEOUT=8, then retry succeeds
    do_reset();
    src_valid  = 4'b1000;
    src_data_3 = 16'h1234;
    tick();
    src_valid = '0;
    tick();
    check("to_req", {28'b0, mux_req}, 32'h8);
    n = 0;
    while (mux_req != 4'b0 && n < 50) begin
      n++;
      tick();
    end
    check("to_len",   n,                    32'd8);
    check("to_err",   {31'b0, err_timeout}, 32'd1);
    check("to_pend",  {28'b0, src_ready},   32'h7);
    serve(0, 1'b0, k, b0, b1, b2);
    check("to_k",     k,                    32'd3);
    check("to_word",  {16'b0, b1, b2},      32'h1234);
    check("to_err2",  {31'b0, err_timeout}, 32'd1);
    check("to_cnt",   {16'b0, tx_count},    32'd1);

    // Asynchronous reset in the middle of SEND
    src_valid  = 4'b0001;
    src_data_0 = 16'h0A0A;
    tick();
    src_valid = '0;
    tick();
    check("mr_req", {28'b0, mux_req}, 32'h1);
    mux_accept = 4'b0001;
    tick();
    mux_winc = 1'b1;
    tick();
    mux_winc = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mr_req0",  {28'b0, mux_req},     32'd0);
    check("mr_ready", {28'b0, src_ready},   32'hF);
    check("mr_cnt",   {16'b0, tx_count},    32'd0);
    check("mr_err",   {31'b0, err_timeout}, 32'd0);
    check("mr_busy",  {31'b0, busy},        32'd0);
    mux_accept = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
